// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, asynchronous
// periodic input in fast-clock cycles and flags lock / loss-of-signal.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TOL         = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             meas_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);

    // Front end
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_d_r;
    logic                   s_s;
    logic                   rise_s;
    logic                   fall_s;

    // Registered state
    state_t           state_r,     state_s;
    logic [CNT_W-1:0] cnt_r,       cnt_s;
    logic [CNT_W-1:0] hcnt_r,      hcnt_s;
    logic [CNT_W-1:0] hi_lat_r,    hi_lat_s;
    logic             fall_seen_r, fall_seen_s;
    logic [CNT_W-1:0] prev_r,      prev_s;
    logic             have_prev_r, have_prev_s;
    logic [CNT_W-1:0] period_r,    period_s;
    logic [CNT_W-1:0] high_time_r, high_time_s;
    logic             valid_r,     valid_s;
    logic             locked_r,    locked_s;
    logic             timeout_r,   timeout_s;

    logic [CNT_W-1:0] diff_s;

    assign s_s    = sync_r[SYNC_STAGES-1];
    assign rise_s = s_s & ~s_d_r;
    assign fall_s = ~s_s & s_d_r;

    // Synchronize meas_in into the clk domain and keep a one-cycle-delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            s_d_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], meas_in};
            s_d_r  <= s_s;
        end
    end

    // Absolute difference between the period just ended and the one before it
    always_comb begin
        diff_s = {CNT_W{1'b0}};
        if (cnt_r >= prev_r) begin
            diff_s = cnt_r - prev_r;
        end else begin
            diff_s = prev_r - cnt_r;
        end
    end

    // Next-state and next-output logic of the measurement FSM
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        hcnt_s      = hcnt_r;
        hi_lat_s    = hi_lat_r;
        fall_seen_s = fall_seen_r;
        prev_s      = prev_r;
        have_prev_s = have_prev_r;
        period_s    = period_r;
        high_time_s = high_time_r;
        valid_s     = 1'b0;
        locked_s    = locked_r;
        timeout_s   = timeout_r;

        case (state_r)
            ST_IDLE: begin
                // First edge only opens a measurement window; nothing to report yet.
                if (rise_s) begin
                    state_s     = ST_RUN;
                    cnt_s       = CNT_ONE;
                    hcnt_s      = CNT_ONE;
                    fall_seen_s = 1'b0;
                    have_prev_s = 1'b0;
                    timeout_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rise_s) begin
                    // A rise wins over the timeout threshold in the same cycle.
                    period_s    = cnt_r;
                    high_time_s = fall_seen_r ? hi_lat_r : hcnt_r;
                    prev_s      = cnt_r;
                    have_prev_s = 1'b1;
                    valid_s     = 1'b1;
                    timeout_s   = 1'b0;
                    if (have_prev_r && (diff_s <= TOL_V)) begin
                        locked_s = 1'b1;
                    end else begin
                        locked_s = 1'b0;
                    end
                    cnt_s       = CNT_ONE;
                    hcnt_s      = CNT_ONE;
                    fall_seen_s = 1'b0;
                end else if (cnt_r == CNT_MAX) begin
                    // Signal lost: report it and wait for a fresh first edge; never wrap.
                    timeout_s = 1'b1;
                    locked_s  = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (s_s) begin
                        hcnt_s = hcnt_r + CNT_ONE;
                    end else begin
                        hcnt_s = hcnt_r;
                    end
                    if (fall_s) begin
                        hi_lat_s    = hcnt_r;
                        fall_seen_s = 1'b1;
                    end else begin
                        hi_lat_s = hi_lat_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and measurement registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            hcnt_r      <= {CNT_W{1'b0}};
            hi_lat_r    <= {CNT_W{1'b0}};
            fall_seen_r <= 1'b0;
            prev_r      <= {CNT_W{1'b0}};
            have_prev_r <= 1'b0;
            period_r    <= {CNT_W{1'b0}};
            high_time_r <= {CNT_W{1'b0}};
            valid_r     <= 1'b0;
            locked_r    <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            hcnt_r      <= hcnt_s;
            hi_lat_r    <= hi_lat_s;
            fall_seen_r <= fall_seen_s;
            prev_r      <= prev_s;
            have_prev_r <= have_prev_s;
            period_r    <= period_s;
            high_time_r <= high_time_s;
            valid_r     <= valid_s;
            locked_r    <= locked_s;
            timeout_r   <= timeout_s;
        end
    end

    assign period     = period_r;
    assign high_time  = high_time_r;
    assign meas_valid = valid_r;
    assign locked     = locked_r;
    assign timeout    = timeout_r;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter (CNT_W=8, SYNC_STAGES=3, TOL=0).
module tb_clk_period_meter;

    localparam int CNT_W = 8;
    localparam int SYNC  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             meas_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    int  vcnt  = 0;
    int  dbl   = 0;
    logic prev_v = 1'b0;

    // waveform generator controls
    logic wave_en = 1'b0;
    int   hi_len  = 2;
    int   lo_len  = 2;
    int   rise_cyc = 0;

    clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TOL(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .meas_in    (meas_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // valid pulse monitor
    always @(negedge clk) begin
        if (meas_valid === 1'b1) vcnt <= vcnt + 1;
        if (meas_valid === 1'b1 && prev_v === 1'b1) dbl <= dbl + 1;
        prev_v <= meas_valid;
    end

    // square-wave generator on meas_in, changes on negedges
    initial begin
        meas_in = 1'b0;
        @(negedge clk);
        forever begin
            if (wave_en) begin
                meas_in  = 1'b1;
                rise_cyc = cyc;
                repeat (hi_len) @(negedge clk);
                meas_in = 1'b0;
                repeat (lo_len) @(negedge clk);
            end else begin
                meas_in = 1'b0;
                @(negedge clk);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_high"},   32'(high_time), 32'd0);
        check({tag, "_valid"},  32'(meas_valid), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_timeout"},32'(timeout), 32'd0);
    endtask

    initial begin
        bit ok;
        int c1, v0, t0, lat;

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // ---- test 1: divide-by-4 waveform ----
        hi_len = 2; lo_len = 2; wave_en = 1'b1;
        wait_valid(60, ok);
        check("t1_valid1", 32'(ok), 32'd1);
        check("t1_period", 32'(period), 32'd4);
        check("t1_high",   32'(high_time), 32'd2);
        check("t1_unlocked_first", 32'(locked), 32'd0);
        c1 = cyc;
        wait_valid(60, ok);
        check("t1_valid2", 32'(ok), 32'd1);
        check("t1_gap",    32'(cyc - c1), 32'd4);
        check("t1_period2", 32'(period), 32'd4);
        check("t1_locked", 32'(locked), 32'd1);

        // ---- test 2: 10 high / 30 low ----
        hi_len = 10; lo_len = 30;
        repeat (3) wait_valid(200, ok);
        wait_valid(200, ok);
        check("t2_valid", 32'(ok), 32'd1);
        c1 = cyc;
        check("t2_period", 32'(period), 32'd40);
        check("t2_high",   32'(high_time), 32'd10);
        check("t2_locked", 32'(locked), 32'd1);
        @(negedge clk);
        check("t2_pulse_1cyc", 32'(meas_valid), 32'd0);
        check("t2_hold_period", 32'(period), 32'd40);
        wait_valid(200, ok);
        check("t2_gap", 32'(cyc - c1), 32'd40);

        // ---- test 3: period 40 -> 44 ----
        lo_len = 34;
        for (int i = 0; i < 4; i++) begin
            wait_valid(200, ok);
            if (period != 8'd40) break;
        end
        check("t3_first44_period", 32'(period), 32'd44);
        check("t3_first44_unlock", 32'(locked), 32'd0);
        wait_valid(200, ok);
        check("t3_second44_period", 32'(period), 32'd44);
        check("t3_second44_high",   32'(high_time), 32'd10);
        check("t3_relock", 32'(locked), 32'd1);

        // ---- test 4: timeout after lock ----
        wave_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_timeout", 32'(ok), 32'd1);
        check("t4_unlocked", 32'(locked), 32'd0);
        check("t4_hold_period", 32'(period), 32'd44);
        check("t4_hold_high",   32'(high_time), 32'd10);
        #1 v0 = vcnt;
        hi_len = 10; lo_len = 30; wave_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (timeout === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_timeout_cleared", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        #1 check("t4_no_valid_first_rise", 32'(vcnt), 32'(v0));
        wait_valid(200, ok);
        check("t4_period_after", 32'(period), 32'd40);
        check("t4_no_lock_one_period", 32'(locked), 32'd0);

        // ---- test 5: reset mid-period (low phase) ----
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("t5_reset");
        t0 = cyc;
        wait_valid(200, ok);
        check("t5_valid", 32'(ok), 32'd1);
        check("t5_not_on_first_rise", 32'((cyc - t0) >= 45), 32'd1);
        check("t5_period", 32'(period), 32'd40);
        check("t5_locked", 32'(locked), 32'd0);

        // ---- test 6: latency from idle ----
        wave_en = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 v0 = vcnt;
        @(negedge clk);
        wave_en = 1'b1;
        repeat (35) @(negedge clk);
        #1 check("t6_no_valid_single_rise", 32'(vcnt), 32'(v0));
        wait_valid(100, ok);
        check("t6_valid_second_rise", 32'(ok), 32'd1);
        lat = cyc - rise_cyc;
        check("t6_latency_window", 32'((lat >= SYNC) && (lat <= SYNC + 2)), 32'd1);
        check("t6_period", 32'(period), 32'd40);

        // ---- never two valid cycles in a row ----
        repeat (2) @(negedge clk);
        #1 check("no_double_valid", 32'(dbl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
